rename_freelist: RTL and testbench
==================================

RENAME_FREELIST -- requirements
Module: rename_freelist

Interface
REQ-001 SHALL have parameter NPHY, default 64, physical register count.
REQ-002 SHALL have parameter NARCH, default 32, architectural register count; DEPTH = NPHY-NARCH free-list entries.
REQ-003 SHALL have parameter TAG_W, default 6, physical tag width.
REQ-004 SHALL have parameter ALLOC_W, default 2, allocation slots per cycle, legal range 1..4.
REQ-005 SHALL have parameter REL_W, default 2, release slots per cycle, legal range 1..4.
REQ-006 SHALL have one clock; reset is asynchronous and active-high. Ports: clk  in  1  clock.
REQ-007 reset  in  1  asynchronous active-high reset.
REQ-008 alloc_req  in  ALLOC_W  bit i: slot i requests a tag.
REQ-009 alloc_tags  out  ALLOC_W*TAG_W  slot i tag, bits [i*TAG_W +: TAG_W].
REQ-010 alloc_ok  out  1  requested tags are granted this cycle.
REQ-011 stall  out  1  request present but not granted.
REQ-012 rel_val  in  REL_W  bit j: release slot j valid.
REQ-013 rel_tags  in  REL_W*TAG_W  released tags from commit.
REQ-014 ckpt_save  in  1  snapshot head pointer for branch.
REQ-015 prmiss  in  1  misprediction: restore head to checkpoint.
REQ-016 free_count  out  TAG_W+1  current number of free entries.
REQ-017 release_err  out  1  sticky over-release error.

Function
REQ-018 SHALL store tags in a circular buffer of DEPTH entries with head, tail and count registers; pointers wrap DEPTH-1 -> 0.
REQ-019 alloc_tags slot i SHALL combinationally equal entry[(head + number of requesting slots below i) mod DEPTH]; non-requesting slots output that same entry, don't-care.
REQ-020 alloc_ok SHALL be 1 iff !prmiss and count >= popcount(alloc_req); grant is all-or-nothing.
REQ-021 stall SHALL equal |alloc_req & !alloc_ok.
REQ-022 On a grant, head SHALL advance by popcount(alloc_req) at the next edge.
REQ-023 Valid releases SHALL be written at tail in ascending slot order; tail advances by popcount(rel_val).
REQ-024 Released tags SHALL NOT be allocatable in the same cycle; they become visible the next cycle.
REQ-025 count_next SHALL = count - granted + released (+ recovered on prmiss); alloc and release in the same cycle both apply.
REQ-026 Any release making count exceed DEPTH SHALL be dropped in full (no write, tail and count unchanged) and set release_err until reset.
REQ-027 ckpt_save SHALL load ckpt_head with head after this cycle's allocation.
REQ-028 prmiss SHALL set head <= ckpt_head, add (head - ckpt_head) mod DEPTH to count, and suppress allocation; same-cycle releases still apply.
REQ-029 prmiss with ckpt_save in the same cycle: prmiss wins; ckpt_head is unchanged.
REQ-030 free_count SHALL be the count register, with no combinational path from inputs.

Reset
REQ-031 Reset SHALL set entry[k] = NARCH+k, head=0, tail=0, count=DEPTH, ckpt_head=0, release_err=0, asynchronously, including mid-operation.
REQ-032 Reset SHALL cause outputs free_count=DEPTH, alloc_ok=1 (with req=0), stall=0.

Verification (defaults, DEPTH=32)
REQ-033 After reset, alloc_req=11 -> alloc_tags={33,32}, alloc_ok=1; next cycle free_count=30.
REQ-034 After reset, alloc_req=10 -> slot1 tag=32; next cycle head=1, free_count=31.
REQ-035 16 cycles of req=11 -> free_count=0; then req=01 with rel_val=01, rel_tags=5 -> stall=1; next cycle req=01 -> tag 5, alloc_ok=1.
REQ-036 ckpt_save at head=4, then 3 cycles of req=11, then prmiss with one release -> head=4, free_count = 28 - 6 + 6 + 1 = 29.
REQ-037 Head at 31, req=11 -> tags from entries 31 and 0; head becomes 1.
REQ-038 At reset state, release tag 40 -> release_err=1, free_count stays 32; assert reset mid-run -> all outputs return to reset values immediately.

Source files
------------

// File: rtl/rename_freelist.sv
// Free list of physical register tags for a rename stage: a circular buffer
// with multi-slot allocate/release and single-checkpoint branch recovery.
module rename_freelist #(
  parameter int NPHY    = 64,
  parameter int NARCH   = 32,
  parameter int TAG_W   = 6,
  parameter int ALLOC_W = 2,
  parameter int REL_W   = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [ALLOC_W-1:0]       alloc_req,
  output logic [ALLOC_W*TAG_W-1:0] alloc_tags,
  output logic                     alloc_ok,
  output logic                     stall,
  input  logic [REL_W-1:0]         rel_val,
  input  logic [REL_W*TAG_W-1:0]   rel_tags,
  input  logic                     ckpt_save,
  input  logic                     prmiss,
  output logic [TAG_W:0]           free_count,
  output logic                     release_err
);

  localparam int DEPTH = NPHY - NARCH;
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = TAG_W + 1;
  localparam int SUM_W = CNT_W + 1;

  logic [TAG_W-1:0] entry_reg [DEPTH];
  logic [PTR_W-1:0] head_reg, head_next;
  logic [PTR_W-1:0] tail_reg, tail_next;
  logic [PTR_W-1:0] ckpt_head_reg, ckpt_head_next;
  logic [CNT_W-1:0] count_reg, count_next;
  logic             release_err_reg, release_err_next;

  logic [PTR_W-1:0] alloc_idx [ALLOC_W];
  logic [PTR_W-1:0] rel_idx [REL_W];
  logic [2:0]       n_alloc, n_rel;
  logic [PTR_W-1:0] alloc_head;
  logic [PTR_W:0]   recov;
  logic [SUM_W-1:0] count_base, count_rel;
  logic             rel_drop;

  // Pointer advance by at most ALLOC_W/REL_W slots, wrapping at DEPTH.
  function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] p, input logic [2:0] n);
    logic [PTR_W:0] s;
    s = (PTR_W+1)'(p) + (PTR_W+1)'(n);
    if (s >= (PTR_W+1)'(DEPTH)) s = s - (PTR_W+1)'(DEPTH);
    return s[PTR_W-1:0];
  endfunction

  // Each slot reads the entry offset by the number of requesting slots below it.
  always_comb begin
    n_alloc = '0;
    for (int i = 0; i < ALLOC_W; i++) begin
      alloc_idx[i] = wrap_add(head_reg, n_alloc);
      n_alloc      = n_alloc + {2'b00, alloc_req[i]};
    end
  end

  always_comb begin
    n_rel = '0;
    for (int j = 0; j < REL_W; j++) begin
      rel_idx[j] = wrap_add(tail_reg, n_rel);
      n_rel      = n_rel + {2'b00, rel_val[j]};
    end
  end

  for (genvar gi = 0; gi < ALLOC_W; gi++) begin : g_alloc_tags
    assign alloc_tags[gi*TAG_W +: TAG_W] = entry_reg[alloc_idx[gi]];
  end

  assign alloc_ok    = !prmiss && (count_reg >= CNT_W'(n_alloc));
  assign stall       = (|alloc_req) && !alloc_ok;
  assign free_count  = count_reg;
  assign release_err = release_err_reg;

  always_comb begin
    alloc_head = alloc_ok ? wrap_add(head_reg, n_alloc) : head_reg;

    recov = '0;
    if (prmiss) begin
      if (head_reg >= ckpt_head_reg)
        recov = (PTR_W+1)'(head_reg) - (PTR_W+1)'(ckpt_head_reg);
      else
        recov = (PTR_W+1)'(head_reg) + (PTR_W+1)'(DEPTH) - (PTR_W+1)'(ckpt_head_reg);
    end

    // Overflow is judged against the count after this cycle's grant/recovery.
    count_base = SUM_W'(count_reg) - (alloc_ok ? SUM_W'(n_alloc) : '0) + SUM_W'(recov);
    count_rel  = count_base + SUM_W'(n_rel);
    rel_drop   = (n_rel != 3'd0) && (count_rel > SUM_W'(DEPTH));

    head_next        = prmiss ? ckpt_head_reg : alloc_head;
    ckpt_head_next   = (ckpt_save && !prmiss) ? alloc_head : ckpt_head_reg;
    tail_next        = rel_drop ? tail_reg : wrap_add(tail_reg, n_rel);
    count_next       = rel_drop ? count_base[CNT_W-1:0] : count_rel[CNT_W-1:0];
    release_err_next = release_err_reg | rel_drop;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < DEPTH; k++) entry_reg[k] <= TAG_W'(NARCH + k);
      head_reg        <= '0;
      tail_reg        <= '0;
      ckpt_head_reg   <= '0;
      count_reg       <= CNT_W'(DEPTH);
      release_err_reg <= 1'b0;
    end else begin
      for (int j = 0; j < REL_W; j++) begin
        if (rel_val[j] && !rel_drop) entry_reg[rel_idx[j]] <= rel_tags[j*TAG_W +: TAG_W];
      end
      head_reg        <= head_next;
      tail_reg        <= tail_next;
      ckpt_head_reg   <= ckpt_head_next;
      count_reg       <= count_next;
      release_err_reg <= release_err_next;
    end
  end

endmodule

// File: tb/tb_rename_freelist.sv
// Directed bench for rename_freelist at default parameters (DEPTH=32):
// allocation, release, stall, wrap, checkpoint recovery, over-release, reset.
module tb_rename_freelist;

  logic        clk;
  logic        reset;
  logic [1:0]  alloc_req;
  logic [11:0] alloc_tags;
  logic        alloc_ok;
  logic        stall;
  logic [1:0]  rel_val;
  logic [11:0] rel_tags;
  logic        ckpt_save;
  logic        prmiss;
  logic [6:0]  free_count;
  logic        release_err;

  int n_vec = 0;
  int n_err = 0;

  rename_freelist dut (
    .clk         (clk),
    .reset       (reset),
    .alloc_req   (alloc_req),
    .alloc_tags  (alloc_tags),
    .alloc_ok    (alloc_ok),
    .stall       (stall),
    .rel_val     (rel_val),
    .rel_tags    (rel_tags),
    .ckpt_save   (ckpt_save),
    .prmiss      (prmiss),
    .free_count  (free_count),
    .release_err (release_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [5:0] tag_of(input int i);
    return alloc_tags[i*6 +: 6];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    alloc_req = '0; rel_val = '0; rel_tags = '0; ckpt_save = 1'b0; prmiss = 1'b0;
    reset = 1'b1;
    #2;
    reset = 1'b0;
    #1;
  endtask

  initial begin
    reset = 1'b1; alloc_req = '0; rel_val = '0; rel_tags = '0; ckpt_save = 1'b0; prmiss = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_free_count", 32'(free_count), 32);
    chk("rst_alloc_ok", 32'(alloc_ok), 1);
    chk("rst_stall", 32'(stall), 0);
    chk("rst_release_err", 32'(release_err), 0);
    reset = 1'b0;
    #1;

    // Two-slot allocation from reset
    alloc_req = 2'b11; #1;
    chk("a11_tag0", 32'(tag_of(0)), 32);
    chk("a11_tag1", 32'(tag_of(1)), 33);
    chk("a11_ok", 32'(alloc_ok), 1);
    chk("a11_stall", 32'(stall), 0);
    tick();
    alloc_req = 2'b00; #1;
    chk("a11_free", 32'(free_count), 30);

    // Only slot 1 requests: it takes the head entry
    do_reset();
    alloc_req = 2'b10; #1;
    chk("a10_tag1", 32'(tag_of(1)), 32);
    chk("a10_ok", 32'(alloc_ok), 1);
    tick();
    alloc_req = 2'b01; #1;
    chk("a10_free", 32'(free_count), 31);
    chk("a10_next_tag0", 32'(tag_of(0)), 33);
    tick();
    alloc_req = 2'b00;

    // Drain completely, then release while empty
    do_reset();
    for (int k = 0; k < 16; k++) begin
      alloc_req = 2'b11; #1;
      chk("drain_tag0", 32'(tag_of(0)), 32'(32 + 2*k));
      chk("drain_tag1", 32'(tag_of(1)), 32'(33 + 2*k));
      tick();
    end
    alloc_req = 2'b00; #1;
    chk("drain_free", 32'(free_count), 0);
    alloc_req = 2'b01; rel_val = 2'b01; rel_tags = {6'd0, 6'd5}; #1;
    chk("empty_stall", 32'(stall), 1);
    chk("empty_ok", 32'(alloc_ok), 0);
    tick();
    rel_val = 2'b00; alloc_req = 2'b01; #1;
    chk("rel_vis_tag0", 32'(tag_of(0)), 5);
    chk("rel_vis_ok", 32'(alloc_ok), 1);
    chk("rel_vis_free", 32'(free_count), 1);
    tick();
    alloc_req = 2'b00; #1;
    chk("rel_vis_free_after", 32'(free_count), 0);

    // Head wraps 31 -> 0
    do_reset();
    for (int k = 0; k < 15; k++) begin
      alloc_req = 2'b11; tick();
    end
    alloc_req = 2'b01; tick();
    alloc_req = 2'b11; rel_val = 2'b11; rel_tags = {6'd8, 6'd7}; #1;
    chk("wrap_short_stall", 32'(stall), 1);
    tick();
    rel_val = 2'b00; alloc_req = 2'b11; #1;
    chk("wrap_free", 32'(free_count), 3);
    chk("wrap_tag0", 32'(tag_of(0)), 63);
    chk("wrap_tag1", 32'(tag_of(1)), 7);
    chk("wrap_ok", 32'(alloc_ok), 1);
    tick();
    alloc_req = 2'b01; #1;
    chk("wrap_head1_tag0", 32'(tag_of(0)), 8);
    tick();
    alloc_req = 2'b00; #1;
    chk("wrap_free_end", 32'(free_count), 0);

    // Checkpoint at head=4, three more grants, then mispredict with a release
    do_reset();
    alloc_req = 2'b11; tick();
    alloc_req = 2'b11; tick();
    alloc_req = 2'b00; ckpt_save = 1'b1; tick();
    ckpt_save = 1'b0;
    for (int k = 0; k < 3; k++) begin
      alloc_req = 2'b11; #1;
      chk("spec_tag0", 32'(tag_of(0)), 32'(36 + 2*k));
      tick();
    end
    alloc_req = 2'b11; prmiss = 1'b1; rel_val = 2'b01; rel_tags = {6'd0, 6'd9}; #1;
    chk("prmiss_ok", 32'(alloc_ok), 0);
    chk("prmiss_stall", 32'(stall), 1);
    tick();
    prmiss = 1'b0; rel_val = 2'b00; alloc_req = 2'b11; #1;
    chk("recov_free", 32'(free_count), 29);
    chk("recov_tag0", 32'(tag_of(0)), 36);
    chk("recov_tag1", 32'(tag_of(1)), 37);
    tick();
    alloc_req = 2'b00;

    // Over-release is dropped and flagged; async reset mid-cycle
    do_reset();
    rel_val = 2'b01; rel_tags = {6'd0, 6'd40}; tick();
    rel_val = 2'b00; #1;
    chk("overrel_err", 32'(release_err), 1);
    chk("overrel_free", 32'(free_count), 32);
    alloc_req = 2'b11; #1;
    chk("overrel_tag0", 32'(tag_of(0)), 32);
    chk("overrel_tag1", 32'(tag_of(1)), 33);
    tick();
    alloc_req = 2'b00; #1;
    chk("pre_rst_free", 32'(free_count), 30);
    reset = 1'b1; #1;
    chk("async_rst_free", 32'(free_count), 32);
    chk("async_rst_err", 32'(release_err), 0);
    chk("async_rst_ok", 32'(alloc_ok), 1);
    chk("async_rst_stall", 32'(stall), 0);
    reset = 1'b0; #1;
    alloc_req = 2'b01; #1;
    chk("post_rst_tag0", 32'(tag_of(0)), 32);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
